// File: rtl/decode_pkg.sv
// decode_pkg: shared constants, types and immediate-extraction helpers for
// the RV32I/RV64I decode stage. Immediates are produced at 64 bits,
// sign-extended; callers keep the low XLEN bits, which is still a correct
// sign extension for XLEN=32.
package decode_pkg;

  localparam int INST_W    = 32;
  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = 5;
  localparam int IMM_MAX_W = 64;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  localparam logic [1:0] RS_RAW = 2'd0;
  localparam logic [1:0] RS_IMM = 2'd1;
  localparam logic [1:0] RS_PC  = 2'd2;

  typedef enum logic [2:0] {
    TYPE_R, TYPE_I, TYPE_S, TYPE_B, TYPE_U, TYPE_J, TYPE_N
  } inst_type_e;

  function automatic inst_type_e type_of(input logic [6:0] opcode);
    case (opcode)
      OP_LUI, OP_AUIPC:                               return TYPE_U;
      OP_JAL:                                         return TYPE_J;
      OP_JALR, OP_LOAD, OP_IMM, OP_MISC_MEM, OP_SYSTEM: return TYPE_I;
      OP_BRANCH:                                      return TYPE_B;
      OP_STORE:                                       return TYPE_S;
      OP_OP:                                          return TYPE_R;
      default:                                        return TYPE_N;
    endcase
  endfunction

  function automatic logic [IMM_MAX_W-1:0] imm_i(input logic [INST_W-1:0] inst);
    return {{52{inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic [IMM_MAX_W-1:0] imm_s(input logic [INST_W-1:0] inst);
    return {{52{inst[31]}}, inst[31:25], inst[11:7]};
  endfunction

  function automatic logic [IMM_MAX_W-1:0] imm_b(input logic [INST_W-1:0] inst);
    return {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [IMM_MAX_W-1:0] imm_u(input logic [INST_W-1:0] inst);
    return {{32{inst[31]}}, inst[31:12], 12'b0};
  endfunction

  function automatic logic [IMM_MAX_W-1:0] imm_j(input logic [INST_W-1:0] inst);
    return {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/decode_if.sv
// decode_if: fetch-to-decode instruction stream.
//   valid  fetch slot holds an instruction
//   ready  decode accepts this cycle
//   pc     instruction address (XLEN)
//   inst   instruction word
// master = fetch side, slave = decode side.
interface decode_if
  import decode_pkg::*;
#(
  parameter int XLEN = 64
);
  logic              valid;
  logic              ready;
  logic [XLEN-1:0]   pc;
  logic [INST_W-1:0] inst;

  modport master (output valid, pc, inst, input ready);
  modport slave  (input valid, pc, inst, output ready);
endinterface

// File: rtl/decode_regfile.sv
// decode_regfile: 32 x XLEN integer register file, 2 read / 1 write.
//   rs1_idx/rs2_idx -> rs1_data/rs2_data  combinational reads, x0 reads 0
//   wen/wr_idx/wr_data                    write at the clock edge, x0 ignored
// With BYPASS=1 a write in flight this cycle is forwarded to the read ports.
module decode_regfile
  import decode_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter bit BYPASS = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] rs1_idx,
  input  logic [REG_IDX_W-1:0] rs2_idx,
  output logic [XLEN-1:0]      rs1_data,
  output logic [XLEN-1:0]      rs2_data,
  input  logic                 wen,
  input  logic [REG_IDX_W-1:0] wr_idx,
  input  logic [XLEN-1:0]      wr_data
);

  logic [XLEN-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wen && wr_idx != '0) begin
      regs[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    rs1_data = regs[rs1_idx];
    if (rs1_idx == '0)                              rs1_data = '0;
    else if (BYPASS && wen && wr_idx == rs1_idx)    rs1_data = wr_data;
  end

  always_comb begin
    rs2_data = regs[rs2_idx];
    if (rs2_idx == '0)                              rs2_data = '0;
    else if (BYPASS && wen && wr_idx == rs2_idx)    rs2_data = wr_data;
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: single-slot RV32I/RV64I decode with register file,
// scoreboard hazard stall, flush and early JAL redirect.
//   fe            fetch stream (decode_if.slave)
//   flush         kill the held instruction, block acceptance this cycle
//   out_*         registered decoded slot, valid/ready to execute
//   jal_valid/addr one-cycle redirect pulse after a JAL is accepted
//   wb_*          write-back / kill port; clears the scoreboard bit
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter bit BYPASS = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  decode_if.slave              fe,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_imm,
  output logic [XLEN-1:0]      out_rs1_data,
  output logic [XLEN-1:0]      out_rs2_data,
  output logic [REG_IDX_W-1:0] out_rs1_idx,
  output logic [REG_IDX_W-1:0] out_rs2_idx,
  output logic [REG_IDX_W-1:0] out_rd_idx,
  output logic [1:0]           out_rs1_type,
  output logic [1:0]           out_rs2_type,
  output logic [16:0]          out_info,
  output logic                 out_wb,
  output logic                 out_rmem,
  output logic                 out_wmem,
  output logic                 out_illegal,
  output logic                 jal_valid,
  output logic [XLEN-1:0]      jal_addr,
  input  logic                 wb_valid,
  input  logic                 wb_wen,
  input  logic [REG_IDX_W-1:0] wb_idx,
  input  logic [XLEN-1:0]      wb_data
);

  logic [6:0]           opcode;
  logic [REG_IDX_W-1:0] rd, rs1, rs2;
  inst_type_e           itype;
  logic [1:0]           rs1_type, rs2_type;
  logic [IMM_MAX_W-1:0] imm64;
  logic [XLEN-1:0]      imm, rs1_data, rs2_data;
  logic                 dec_wb, illegal, hazard, fire_in, fire_out;
  logic [NUM_REGS-1:0]  sb, sb_live, sb_nxt, wb_clr, flush_clr, set_mask;

  assign opcode  = fe.inst[6:0];
  assign rd      = fe.inst[11:7];
  assign rs1     = fe.inst[19:15];
  assign rs2     = fe.inst[24:20];
  assign itype   = type_of(opcode);
  assign illegal = (itype == TYPE_N);
  assign dec_wb  = itype inside {TYPE_R, TYPE_I, TYPE_U, TYPE_J};

  always_comb begin
    rs1_type = RS_IMM;
    rs2_type = RS_IMM;
    case (opcode)
      OP_AUIPC:                  rs1_type = RS_PC;
      OP_JAL, OP_JALR:           begin rs1_type = RS_PC;  rs2_type = RS_PC;  end
      OP_BRANCH, OP_OP:          begin rs1_type = RS_RAW; rs2_type = RS_RAW; end
      OP_LOAD, OP_STORE, OP_IMM: rs1_type = RS_RAW;
      default: ;
    endcase
  end

  always_comb begin
    case (itype)
      TYPE_I:  imm64 = imm_i(fe.inst);
      TYPE_S:  imm64 = imm_s(fe.inst);
      TYPE_B:  imm64 = imm_b(fe.inst);
      TYPE_U:  imm64 = imm_u(fe.inst);
      TYPE_J:  imm64 = imm_j(fe.inst);
      default: imm64 = '0;
    endcase
  end
  assign imm = imm64[XLEN-1:0];

  // A bit retired this very cycle no longer blocks issue; bit 0 is never set.
  assign wb_clr  = wb_valid ? (NUM_REGS'(1) << wb_idx) : '0;
  assign sb_live = sb & ~wb_clr;

  assign hazard = fe.valid & ((rs1_type == RS_RAW && sb_live[rs1]) ||
                              (rs2_type == RS_RAW && sb_live[rs2]) ||
                              (dec_wb && sb_live[rd]));

  assign fe.ready = (~out_valid | out_ready) & ~hazard & ~flush;
  assign fire_in  = fe.valid & fe.ready;
  assign fire_out = out_valid & out_ready;

  // A flushed writer will never reach write-back, so release its bit here.
  assign flush_clr = (flush && out_valid && out_wb) ? (NUM_REGS'(1) << out_rd_idx) : '0;
  assign set_mask  = (fire_in && dec_wb) ? (NUM_REGS'(1) << rd) : '0;
  assign sb_nxt    = ((sb & ~wb_clr & ~flush_clr) | set_mask) & ~NUM_REGS'(1);

  decode_regfile #(.XLEN(XLEN), .BYPASS(BYPASS)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_idx  (rs1),
    .rs2_idx  (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .wen      (wb_valid & wb_wen),
    .wr_idx   (wb_idx),
    .wr_data  (wb_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb           <= '0;
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_imm      <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_rs1_idx  <= '0;
      out_rs2_idx  <= '0;
      out_rd_idx   <= '0;
      out_rs1_type <= '0;
      out_rs2_type <= '0;
      out_info     <= '0;
      out_wb       <= 1'b0;
      out_rmem     <= 1'b0;
      out_wmem     <= 1'b0;
      out_illegal  <= 1'b0;
      jal_valid    <= 1'b0;
      jal_addr     <= '0;
    end else begin
      sb        <= sb_nxt;
      jal_valid <= fire_in && opcode == OP_JAL;
      if (fire_in && opcode == OP_JAL) jal_addr <= fe.pc + imm;

      if (flush) begin
        out_valid <= 1'b0;
      end else if (fire_in) begin
        out_valid    <= 1'b1;
        out_pc       <= fe.pc;
        out_imm      <= imm;
        out_rs1_data <= rs1_data;
        out_rs2_data <= rs2_data;
        out_rs1_idx  <= rs1;
        out_rs2_idx  <= rs2;
        out_rd_idx   <= rd;
        out_rs1_type <= rs1_type;
        out_rs2_type <= rs2_type;
        out_info     <= {opcode, fe.inst[31:25], fe.inst[14:12]};
        out_wb       <= dec_wb;
        out_rmem     <= (opcode == OP_LOAD);
        out_wmem     <= (opcode == OP_STORE);
        out_illegal  <= illegal;
      end else if (fire_out) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  import decode_pkg::*;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [63:0] d1;
    logic [63:0] d2;
    logic [4:0]  rd;
    logic [1:0]  t1;
    logic [1:0]  t2;
    logic        wb;
    logic        rmem;
    logic        wmem;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_if #(.XLEN(64)) fe ();
  decode_if #(.XLEN(32)) fe32 ();

  logic        flush = 1'b0, out_ready = 1'b1;
  logic        wb_valid = 1'b0, wb_wen = 1'b0;
  logic [4:0]  wb_idx = '0;
  logic [63:0] wb_data = '0;

  logic        out_valid, out_wb, out_rmem, out_wmem, out_illegal, jal_valid;
  logic [63:0] out_pc, out_imm, out_rs1_data, out_rs2_data, jal_addr;
  logic [4:0]  out_rs1_idx, out_rs2_idx, out_rd_idx;
  logic [1:0]  out_rs1_type, out_rs2_type;
  logic [16:0] out_info;

  logic        o32_valid, o32_wb, o32_rmem, o32_wmem, o32_ill, j32_valid;
  logic [31:0] o32_pc, o32_imm, o32_d1, o32_d2, j32_addr;
  logic [4:0]  o32_i1, o32_i2, o32_rd;
  logic [1:0]  o32_t1, o32_t2;
  logic [16:0] o32_info;

  decode_stage #(.XLEN(64), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .fe(fe), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rs1_idx(out_rs1_idx), .out_rs2_idx(out_rs2_idx), .out_rd_idx(out_rd_idx),
    .out_rs1_type(out_rs1_type), .out_rs2_type(out_rs2_type), .out_info(out_info),
    .out_wb(out_wb), .out_rmem(out_rmem), .out_wmem(out_wmem), .out_illegal(out_illegal),
    .jal_valid(jal_valid), .jal_addr(jal_addr),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_idx(wb_idx), .wb_data(wb_data)
  );

  decode_stage #(.XLEN(32), .BYPASS(1'b1)) dut32 (
    .clk(clk), .rst_n(rst_n), .fe(fe32), .flush(1'b0),
    .out_valid(o32_valid), .out_ready(1'b1),
    .out_pc(o32_pc), .out_imm(o32_imm), .out_rs1_data(o32_d1), .out_rs2_data(o32_d2),
    .out_rs1_idx(o32_i1), .out_rs2_idx(o32_i2), .out_rd_idx(o32_rd),
    .out_rs1_type(o32_t1), .out_rs2_type(o32_t2), .out_info(o32_info),
    .out_wb(o32_wb), .out_rmem(o32_rmem), .out_wmem(o32_wmem), .out_illegal(o32_ill),
    .jal_valid(j32_valid), .jal_addr(j32_addr),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_idx(wb_idx), .wb_data(wb_data[31:0])
  );

  int total = 0;
  int bad = 0;
  exp_t exp_q[$];
  logic [63:0] rf_m [32];
  exp_t e, g, snap;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] pc, input logic [31:0] inst);
    fe.valid = 1'b1;
    fe.pc    = pc;
    fe.inst  = inst;
  endtask

  task automatic set_wb(input logic v, input logic wen, input logic [4:0] idx, input logic [63:0] data);
    wb_valid = v;
    wb_wen   = wen;
    wb_idx   = idx;
    wb_data  = data;
  endtask

  task automatic push(input logic [63:0] pc, input logic [63:0] imm, input int i1, input int i2,
                      input logic [4:0] rd, input logic [1:0] t1, input logic [1:0] t2,
                      input logic wb, input logic rm, input logic wm, input logic il);
    exp_t x;
    x.pc = pc; x.imm = imm; x.d1 = rf_m[i1]; x.d2 = rf_m[i2];
    x.rd = rd; x.t1 = t1; x.t2 = t2; x.wb = wb; x.rmem = rm; x.wmem = wm; x.ill = il;
    exp_q.push_back(x);
  endtask

  function automatic exp_t grab();
    exp_t x;
    x.pc = out_pc; x.imm = out_imm; x.d1 = out_rs1_data; x.d2 = out_rs2_data;
    x.rd = out_rd_idx; x.t1 = out_rs1_type; x.t2 = out_rs2_type;
    x.wb = out_wb; x.rmem = out_rmem; x.wmem = out_wmem; x.ill = out_illegal;
    return x;
  endfunction

  task automatic test_reset();
    fe.valid = 1'b0; fe.pc = '0; fe.inst = '0;
    fe32.valid = 1'b0; fe32.pc = '0; fe32.inst = '0;
    for (int i = 0; i < 32; i++) rf_m[i] = '0;
    rst_n = 1'b0;
    repeat (2) tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (jal_valid !== 1'b0) begin bad++; $display("FAIL reset_jal_valid got=%b want=0", jal_valid); end
    total++; if (dut.sb !== 32'h0) begin bad++; $display("FAIL reset_sb got=%h want=0", dut.sb); end
    total++; if (grab() !== '0) begin bad++; $display("FAIL reset_fields got=%h want=0", grab()); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_addi();
    drive(64'h100, 32'h00500093);
    push(64'h100, 64'd5, 0, 5, 5'd1, RS_RAW, RS_IMM, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    total++; if (fe.ready !== 1'b1) begin bad++; $display("FAIL addi_in_ready got=%b want=1", fe.ready); end
    tick();
    fe.valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL addi_out_valid got=%b want=1", out_valid); end
    e = exp_q.pop_front(); g = grab();
    total++; if (g !== e) begin bad++; $display("FAIL addi_fields got=%h want=%h", g, e); end
    total++; if (dut.sb[1] !== 1'b1) begin bad++; $display("FAIL addi_sb1 got=%b want=1", dut.sb[1]); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL addi_drain got=%b want=0", out_valid); end
    set_wb(1'b1, 1'b1, 5'd1, 64'd5);
    tick();
    rf_m[1] = 64'd5;
    set_wb(1'b0, 1'b0, 5'd0, 64'd0);
  endtask

  task automatic test_back_to_back();
    drive(64'h200, 32'h00700093);
    push(64'h200, 64'd7, 0, 7, 5'd1, RS_RAW, RS_IMM, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(64'h204, 32'h00108133);
    #1;
    total++; if (fe.ready !== 1'b0) begin bad++; $display("FAIL raw_stall_1 got=%b want=0", fe.ready); end
    e = exp_q.pop_front(); g = grab();
    total++; if (g !== e) begin bad++; $display("FAIL b2b_addi got=%h want=%h", g, e); end
    tick();
    total++; if (fe.ready !== 1'b0) begin bad++; $display("FAIL raw_stall_2 got=%b want=0", fe.ready); end
    set_wb(1'b1, 1'b1, 5'd1, 64'h77);
    rf_m[1] = 64'h77;
    #1;
    total++; if (fe.ready !== 1'b1) begin bad++; $display("FAIL wb_release got=%b want=1", fe.ready); end
    push(64'h204, 64'd0, 1, 1, 5'd2, RS_RAW, RS_RAW, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_wb(1'b0, 1'b0, 5'd0, 64'd0);
    fe.valid = 1'b0;
    #1;
    e = exp_q.pop_front(); g = grab();
    total++; if (g !== e) begin bad++; $display("FAIL b2b_add_bypass got=%h want=%h", g, e); end
    total++; if (dut.sb[2:1] !== 2'b10) begin bad++; $display("FAIL b2b_sb got=%b want=10", dut.sb[2:1]); end
    set_wb(1'b1, 1'b0, 5'd2, 64'hdead);
    tick();
    set_wb(1'b0, 1'b0, 5'd0, 64'd0);
    #1;
    total++; if (dut.sb !== 32'h0) begin bad++; $display("FAIL kill_clears_sb got=%h want=0", dut.sb); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    drive(64'h300, 32'h0F00F213);
    push(64'h300, 64'hF0, 1, 16, 5'd4, RS_RAW, RS_IMM, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(64'h304, 32'h00102423);
    #1;
    snap = grab();
    for (int i = 0; i < 3; i++) begin
      total++; if (fe.ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready cyc=%0d got=%b want=0", i, fe.ready); end
      g = grab();
      total++; if (out_valid !== 1'b1 || g !== snap) begin bad++; $display("FAIL stall_hold cyc=%0d got=%h want=%h", i, g, snap); end
      tick();
    end
    e = exp_q.pop_front(); g = grab();
    total++; if (g !== e) begin bad++; $display("FAIL stall_andi got=%h want=%h", g, e); end
    out_ready = 1'b1;
    #1;
    total++; if (fe.ready !== 1'b1) begin bad++; $display("FAIL stall_release got=%b want=1", fe.ready); end
    push(64'h304, 64'd8, 0, 1, 5'd8, RS_RAW, RS_IMM, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    fe.valid = 1'b0;
    #1;
    e = exp_q.pop_front(); g = grab();
    total++; if (g !== e) begin bad++; $display("FAIL stall_sw got=%h want=%h", g, e); end
    total++; if (dut.sb !== 32'h10) begin bad++; $display("FAIL stall_sb got=%h want=10", dut.sb); end
    set_wb(1'b1, 1'b1, 5'd4, 64'h70);
    tick();
    rf_m[4] = 64'h70;
    set_wb(1'b0, 1'b0, 5'd0, 64'd0);
  endtask

  task automatic test_jal();
    drive(64'h1000, 32'hFF9FF0EF);
    fe32.valid = 1'b1; fe32.pc = 32'h4; fe32.inst = 32'hFF9FF0EF;
    push(64'h1000, 64'hFFFF_FFFF_FFFF_FFF8, 31, 25, 5'd1, RS_PC, RS_PC, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    total++; if (jal_valid !== 1'b0) begin bad++; $display("FAIL jal_pre got=%b want=0", jal_valid); end
    tick();
    fe.valid = 1'b0; fe32.valid = 1'b0;
    #1;
    total++; if (jal_valid !== 1'b1 || jal_addr !== 64'hFF8) begin bad++; $display("FAIL jal64 got=%b/%h want=1/ff8", jal_valid, jal_addr); end
    total++; if (j32_valid !== 1'b1 || j32_addr !== 32'hFFFFFFFC) begin bad++; $display("FAIL jal32 got=%b/%h want=1/fffffffc", j32_valid, j32_addr); end
    e = exp_q.pop_front(); g = grab();
    total++; if (g !== e) begin bad++; $display("FAIL jal_fields got=%h want=%h", g, e); end
    tick();
    total++; if (jal_valid !== 1'b0) begin bad++; $display("FAIL jal_pulse_len got=%b want=0", jal_valid); end
    set_wb(1'b1, 1'b0, 5'd1, 64'd0);
    tick();
    set_wb(1'b0, 1'b0, 5'd0, 64'd0);
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(64'h400, 32'h00002183);
    push(64'h400, 64'd0, 0, 0, 5'd3, RS_RAW, RS_IMM, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(64'h404, 32'h00100293);
    #1;
    total++; if (dut.sb[3] !== 1'b1) begin bad++; $display("FAIL lw_sb3 got=%b want=1", dut.sb[3]); end
    e = exp_q.pop_front(); g = grab();
    total++; if (g !== e) begin bad++; $display("FAIL lw_fields got=%h want=%h", g, e); end
    flush = 1'b1;
    #1;
    total++; if (fe.ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b want=0", fe.ready); end
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
    total++; if (dut.sb[3] !== 1'b0) begin bad++; $display("FAIL flush_sb3 got=%b want=0", dut.sb[3]); end
    push(64'h404, 64'd1, 0, 1, 5'd5, RS_RAW, RS_IMM, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    fe.valid = 1'b0;
    #1;
    e = exp_q.pop_front(); g = grab();
    total++; if (g !== e) begin bad++; $display("FAIL post_flush got=%h want=%h", g, e); end
    set_wb(1'b1, 1'b0, 5'd5, 64'd0);
    tick();
    set_wb(1'b0, 1'b0, 5'd0, 64'd0);
  endtask

  task automatic test_illegal();
    drive(64'h500, 32'h0000037F);
    push(64'h500, 64'd0, 0, 0, 5'd6, RS_IMM, RS_IMM, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    fe.valid = 1'b0;
    #1;
    e = exp_q.pop_front(); g = grab();
    total++; if (g !== e) begin bad++; $display("FAIL illegal_fields got=%h want=%h", g, e); end
    total++; if (out_info !== {7'h7F, 7'h00, 3'h0}) begin bad++; $display("FAIL illegal_info got=%h want=%h", out_info, {7'h7F, 7'h00, 3'h0}); end
    total++; if (dut.sb !== 32'h0) begin bad++; $display("FAIL illegal_sb got=%h want=0", dut.sb); end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(64'h600, 32'h00100313);
    tick();
    drive(64'h604, 32'h004083B3);
    #1;
    total++; if (fe.ready !== 1'b0) begin bad++; $display("FAIL mid_stall got=%b want=0", fe.ready); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", out_valid); end
    total++; if (dut.sb !== 32'h0) begin bad++; $display("FAIL mid_rst_sb got=%h want=0", dut.sb); end
    for (int i = 0; i < 32; i++) rf_m[i] = '0;
    tick();
    rst_n = 1'b1;
    #1;
    total++; if (fe.ready !== 1'b1) begin bad++; $display("FAIL mid_rst_recover got=%b want=1", fe.ready); end
    push(64'h604, 64'd0, 1, 4, 5'd7, RS_RAW, RS_RAW, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    fe.valid = 1'b0;
    #1;
    e = exp_q.pop_front(); g = grab();
    total++; if (g !== e) begin bad++; $display("FAIL post_reset_add got=%h want=%h", g, e); end
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_stall();
    test_jal();
    test_flush();
    test_illegal();
    test_reset_mid();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL leftover_expected got=%0d want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
